// File: rtl/layer5_pkg.sv
// Shared constants and FSM state encoding for the layer-5 feature-map writer.
package layer5_pkg;
  localparam int L5_DATA_W = 16;
  localparam int L5_LANES  = 8;
  localparam int L5_DEPTH  = 112;
  localparam int L5_ADDR_W = 7;

  typedef enum logic [1:0] {IDLE, PACK, WRITE, DONE} l5_state_e;
endpackage

// File: rtl/layer5_packer.sv
// Packs LANES channel beats into one SRAM word, lane 0 in the LSBs.
// Build option: define LAYER5_RELU_EN to clamp negative beats to zero before packing.
module layer5_packer
  import layer5_pkg::*;
#(
  parameter int DATA_W = L5_DATA_W,
  parameter int LANES  = L5_LANES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic                    i_beat,
  input  logic [DATA_W-1:0]       i_data,
  output logic [LANES*DATA_W-1:0] o_word,
  output logic                    o_last,
  output logic                    o_word_full
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LW-1:0]           r_lane;
  logic [LANES*DATA_W-1:0] r_word;
  logic                    r_full;
  logic [DATA_W-1:0]       w_data;
  logic                    w_last;

`ifdef LAYER5_RELU_EN
  assign w_data = i_data[DATA_W-1] ? '0 : i_data;
`else
  assign w_data = i_data;
`endif

  assign w_last = i_beat && (r_lane == LW'(LANES-1));

  // r_full is high for exactly the cycle after the closing beat: the write cycle.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_lane <= '0;
      r_word <= '0;
      r_full <= 1'b0;
    end else begin
      r_full <= w_last;
      if (i_beat) begin
        r_word[r_lane*DATA_W +: DATA_W] <= w_data;
        r_lane <= w_last ? '0 : r_lane + 1'b1;
      end
    end
  end

  assign o_word      = r_word;
  assign o_last      = w_last;
  assign o_word_full = r_full;
endmodule

// File: rtl/layer5_writer.sv
// Streams signed channel beats into DEPTH packed words on SRAM port A.
// Build option: LAYER5_RELU_EN (handled in layer5_packer) zeroes negative beats.
module layer5_writer
  import layer5_pkg::*;
#(
  parameter int DATA_W = L5_DATA_W,
  parameter int LANES  = L5_LANES,
  parameter int DEPTH  = L5_DEPTH,
  parameter int ADDR_W = L5_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    sram_wean,
  output logic                    sram_oea,
  output logic [ADDR_W-1:0]       sram_a,
  output logic [LANES*DATA_W-1:0] sram_dia,
  output logic                    busy,
  output logic                    done
);
  l5_state_e               r_state;
  logic [ADDR_W-1:0]       r_cnt;
  logic                    r_rdy;
  logic                    r_busy;
  logic                    r_done;
  logic                    w_beat;
  logic                    w_clr;
  logic                    w_last;
  logic                    w_full;
  logic [LANES*DATA_W-1:0] w_word;

  assign w_beat = in_valid && r_rdy;
  assign w_clr  = start && ((r_state == IDLE) || (r_state == DONE));

  layer5_packer #(.DATA_W(DATA_W), .LANES(LANES)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_clr),
    .i_beat     (w_beat),
    .i_data     (in_data),
    .o_word     (w_word),
    .o_last     (w_last),
    .o_word_full(w_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdy   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: if (start) begin
          r_state <= PACK;
          r_cnt   <= '0;
          r_rdy   <= 1'b1;
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
        end
        PACK: if (w_last) begin
          r_state <= WRITE;
          r_rdy   <= 1'b0;
        end
        WRITE: begin
          // Counter stops at DEPTH-1 so the address never leaves the map.
          if (r_cnt < ADDR_W'(DEPTH-1)) begin
            r_state <= PACK;
            r_cnt   <= r_cnt + 1'b1;
            r_rdy   <= 1'b1;
          end else begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_rdy;
  assign sram_wean = ~(w_full && (r_state == WRITE));
  assign sram_oea  = 1'b0;
  assign sram_a    = r_cnt;
  assign sram_dia  = w_word;
  assign busy      = r_busy;
  assign done      = r_done;
endmodule

// File: tb/tb_layer5_writer.sv
// Directed + randomized bench for layer5_writer against a beat-level fill model.
module tb_layer5_writer;
  localparam int DEPTH = 112;
  localparam int LANES = 8;
`ifdef LAYER5_RELU_EN
  localparam logic [15:0] LANE3_EXP = 16'h0000;
`else
  localparam logic [15:0] LANE3_EXP = 16'hFFF0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [15:0]  in_data = '0;
  logic         sram_wean, sram_oea, busy, done;
  logic [6:0]   sram_a;
  logic [127:0] sram_dia;

  layer5_writer dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sram_wean(sram_wean), .sram_oea(sram_oea), .sram_a(sram_a),
    .sram_dia(sram_dia), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int nerr = 0, nchk = 0;
  // Model: ph 0=idle 1=filling 2=done; words = words completed in this fill.
  int ph = 0, lane = 0, words = 0;
  bit m_wpend = 0, m_rdy = 0;
  logic [127:0] mword = '0, exp_d = '0;
  int exp_a = 0, nwr = 0, maxa = -1, first_a = -1;
  bit f3 = 0, mid_arm = 0;

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    nchk++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick();
    bit acc, st, wp;
    logic [15:0] v;
    acc = in_valid && m_rdy && !rst;
    st  = start && (ph != 1) && !rst;
    wp  = 0;
    if (rst) begin
      ph = 0; lane = 0; words = 0;
    end else begin
      if (m_wpend && words == DEPTH) ph = 2;
      if (st) begin
        ph = 1; words = 0; lane = 0; mword = '0; nwr = 0; maxa = -1; first_a = -1;
      end
      if (acc) begin
        v = in_data;
`ifdef LAYER5_RELU_EN
        if (v[15]) v = 16'h0000;
`endif
        mword[lane*16 +: 16] = v;
        lane++;
        if (lane == LANES) begin
          exp_a = words; exp_d = mword; words++; lane = 0; wp = 1;
        end
      end
    end
    m_wpend = wp;
    m_rdy   = (ph == 1) && !wp;
    @(posedge clk); #1;
    chk("wean", sram_wean, !wp);
    chk("busy", busy, ph == 1);
    chk("done", done, ph == 2);
    chk("in_ready", in_ready, m_rdy);
    chk("oea", sram_oea, 1'b0);
    if (wp) begin
      chk("addr", sram_a, exp_a);
      chk("data", sram_dia, exp_d);
      if (first_a < 0) first_a = int'(sram_a);
      nwr++;
      if (int'(sram_a) > maxa) maxa = int'(sram_a);
      if (f3 && exp_a == 1) chk("relu_lane3", sram_dia[63:48], LANE3_EXP);
    end
  endtask

  task automatic beats(input int n, input bit gaps);
    int got = 0, guard = 0;
    while (got < n && guard < 8000) begin
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = 16'($urandom);
      if (f3 && words == 1 && lane == 3) in_data = 16'hFFF0;
      if (mid_arm && words == 40 && lane == 2) begin
        start = 1'b1; mid_arm = 0;
      end
      if (in_valid && m_rdy) got++;
      tick();
      start = 1'b0;
      guard++;
    end
    in_valid = 1'b0;
    chk("beats_accepted", got, n);
  endtask

  task automatic settle();
    int guard = 0;
    while (ph != 2 && guard < 20) begin tick(); guard++; end
    chk("reached_done", ph, 2);
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    chk("rst_a", sram_a, 7'd0);
    chk("rst_dia", sram_dia, 128'd0);
    chk("rst_wean", sram_wean, 1'b1);

    // Directed first word: 0x0001..0x0008 back-to-back.
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      in_valid = 1'b1; in_data = 16'(k + 1); tick();
    end
    in_valid = 1'b0;
    chk("w0_wean", sram_wean, 1'b0);
    chk("w0_addr", sram_a, 7'd0);
    chk("w0_dia", sram_dia, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    chk("w0_ready", in_ready, 1'b0);

    // Rest of the fill with gaps, a ReLU probe in word 1 and a stray start at word 40.
    f3 = 1; mid_arm = 1;
    beats((DEPTH - 1) * LANES, 1'b1);
    f3 = 0;
    settle();
    chk("fill_writes", nwr, DEPTH);
    chk("fill_max_addr", maxa, DEPTH - 1);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    in_valid = 1'b0;
    chk("no_extra_writes", nwr, DEPTH);

    // Restart from DONE, then reset after 5 beats of word 10.
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_done_low", done, 1'b0);
    beats(10 * LANES + 5, 1'b1);
    chk("restart_first_addr", first_a, 0);
    rst = 1'b1; in_valid = 1'b1; tick(); rst = 1'b0; in_valid = 1'b0;
    chk("mid_rst_a", sram_a, 7'd0);
    chk("mid_rst_dia", sram_dia, 128'd0);
    chk("mid_rst_wean", sram_wean, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);

    start = 1'b1; tick(); start = 1'b0;
    beats(LANES, 1'b1);
    tick();
    chk("post_rst_first_addr", first_a, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
